// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin packet arbiter that shares one UART byte transmitter among NUM_REQ
//          sources, optionally prefixing each granted packet with a one-byte channel header.
// Latency: one IDLE arbitration cycle per packet; header and data bytes are then zero-bubble.
//          In DATA, requester valid/data go straight through to tx, and tx_ready goes straight
//          back to the granted requester.
// Backpressure: tx_ready stalls the header and data in place. Requesters that are not granted
//          see req_ready=0. A granted requester that drops valid holds the grant indefinitely.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int HDR_EN  = 1,
  parameter int MAX_PKT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   pkt_trunc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // Header byte: fixed 5-bit tag followed by the granted channel index.
  localparam logic [4:0] HDR_TAG = 5'b10100;

  state_t      state_q;
  logic [2:0]  grant_q;
  logic [2:0]  rr_ptr_q;
  logic [7:0]  cnt_q;
  logic        trunc_q;

  // Requester buses are padded to the 8-requester maximum so that the 3-bit grant
  // index can select from them for every legal NUM_REQ.
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;
  logic [7:0]  ready_pad;

  assign valid_pad = 8'(req_valid);
  assign last_pad  = 8'(req_last);
  assign data_pad  = 64'(req_data);

  // Signals of the granted requester.
  logic        g_vld;
  logic        g_last;
  logic [7:0]  g_dat;
  logic        accept;
  logic [7:0]  cnt_d;
  logic        hit_max;
  logic [2:0]  rr_ptr_d;

  assign g_vld    = valid_pad[grant_q];
  assign g_last   = last_pad[grant_q];
  assign g_dat    = data_pad[{grant_q, 3'b000} +: 8];
  assign accept   = (state_q == S_DATA) && g_vld && tx_ready;
  assign cnt_d    = cnt_q + 8'd1;
  assign hit_max  = (cnt_d == 8'(MAX_PKT));
  assign rr_ptr_d = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;

  logic [2:0]  pick;
  logic        any_vld;
  logic [3:0]  scan_idx;

  // Pick the first valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick     = 3'd0;
    any_vld  = 1'b0;
    scan_idx = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + 4'(k);
      if (scan_idx >= 4'(NUM_REQ)) begin
        scan_idx = scan_idx - 4'(NUM_REQ);
      end
      if (!any_vld && valid_pad[scan_idx[2:0]]) begin
        pick    = scan_idx[2:0];
        any_vld = 1'b1;
      end
    end
  end

  // Arbitration, header/data sequencing, packet byte count and truncation pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= 3'd0;
      rr_ptr_q <= 3'd0;
      cnt_q    <= 8'd0;
      trunc_q  <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_vld) begin
            grant_q <= pick;
            cnt_q   <= 8'd0;
            state_q <= (HDR_EN != 0) ? S_HDR : S_DATA;
          end
        end
        S_HDR: begin
          if (tx_ready) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            cnt_q <= cnt_d;
            // A last byte closes the packet normally. Reaching MAX_PKT without a
            // last byte force-releases the grant, and that is flagged next cycle.
            if (g_last || hit_max) begin
              state_q  <= S_IDLE;
              rr_ptr_q <= rr_ptr_d;
              trunc_q  <= !g_last;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output mux: the header comes from registered state, and data is pure pass-through.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'd0;
    ready_pad = 8'd0;
    case (state_q)
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = {HDR_TAG, grant_q};
      end
      S_DATA: begin
        tx_valid           = g_vld;
        tx_data            = g_dat;
        ready_pad[grant_q] = tx_ready;
      end
      default: begin
      end
    endcase
  end

  assign req_ready = ready_pad[NUM_REQ-1:0];
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_q;
  assign pkt_trunc = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter.
// Four queue-driven sources feed the DUT. Each test pushes its expected tx byte stream into a queue,
// and a negedge monitor pops and compares every accepted tx byte.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic          clk;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          busy;
  logic [2:0]    grant_id;
  logic          pkt_trunc;

  uart_tx_arbiter #(.NUM_REQ(NR), .HDR_EN(1), .MAX_PKT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .grant_id(grant_id), .pkt_trunc(pkt_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int trunc_cnt = 0;
  int tx_mode = 0;            // 0: tx_ready=1, 1: toggle every cycle, 2: tx_ready=0
  logic [8:0] src_q [NR][$];  // {last, data} per source
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      @(posedge clk); #2;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
    check({tag, "_tx_data"},   32'(tx_data),   32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_grant_id"},  32'(grant_id),  32'd0);
    check({tag, "_pkt_trunc"}, 32'(pkt_trunc), 32'd0);
  endtask

  // Source and tx_ready driver: after each rising edge, retire the bytes that were accepted and present each queue head.
  initial begin
    logic [NR-1:0] fire;
    logic [8:0]    tmp;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (fire[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
        if (src_q[i].size() > 0) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = src_q[i][0][7:0];
          req_last[i]         = src_q[i][0][8];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'hEE;
          req_last[i]         = 1'b0;
        end
      end
      case (tx_mode)
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor: score every accepted tx byte, check that a stalled tx byte holds, and count truncation pulses.
  initial begin
    logic       hold;
    logic [7:0] hold_dat;
    logic [7:0] e;
    hold = 1'b0;
    hold_dat = 8'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (pkt_trunc) trunc_cnt++;
        if (hold) begin
          checks++;
          if (!tx_valid || tx_data != hold_dat) begin
            errors++;
            $display("FAIL tx_hold: actual valid %0b data %02h required valid 1 data %02h",
                     tx_valid, tx_data, hold_dat);
          end
        end
        if (tx_valid && tx_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: actual %02h required no byte", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data != e) begin
              errors++;
              $display("FAIL tx_byte: actual %02h required %02h", tx_data, e);
            end
          end
        end
        hold     = tx_valid && !tx_ready;
        hold_dat = tx_data;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc, rc, oc, tc0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    reset = 1'b0;

    // Single packet from requester 2.
    src_q[2].push_back(9'h011); src_q[2].push_back(9'h022); src_q[2].push_back(9'h133);
    push_exp(8'hA2); push_exp(8'h11); push_exp(8'h22); push_exp(8'h33);
    bc = 0; rc = 0; oc = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) bc++;
      if (req_ready[2]) rc++;
      if ((req_ready & 4'b1011) != 4'b0000) oc++;
    end
    check("single_busy_cycles", 32'(bc), 32'd4);
    check("single_ready_cycles", 32'(rc), 32'd3);
    check("single_other_ready", 32'(oc), 32'd0);
    check("single_grant_id", 32'(grant_id), 32'd2);
    check("single_drained", 32'(exp_q.size()), 32'd0);

    // Round-robin from reset: requesters 0, 1 and 3 each hold two 1-byte packets.
    do_reset();
    src_q[0].push_back(9'h101); src_q[0].push_back(9'h102);
    src_q[1].push_back(9'h111); src_q[1].push_back(9'h112);
    src_q[3].push_back(9'h131); src_q[3].push_back(9'h132);
    push_exp(8'hA0); push_exp(8'h01); push_exp(8'hA1); push_exp(8'h11);
    push_exp(8'hA3); push_exp(8'h31); push_exp(8'hA0); push_exp(8'h02);
    push_exp(8'hA1); push_exp(8'h12); push_exp(8'hA3); push_exp(8'h32);
    wait_drain("rr_order", 80);

    // tx backpressure: tx_ready toggles every cycle through the header and data.
    tx_mode = 1;
    src_q[0].push_back(9'h05A); src_q[0].push_back(9'h0C3); src_q[0].push_back(9'h196);
    push_exp(8'hA0); push_exp(8'h5A); push_exp(8'hC3); push_exp(8'h96);
    wait_drain("bp_sequence", 60);
    tx_mode = 0;
    repeat (3) @(posedge clk);
    #2;

    // Source stall: granted requester 1 runs dry mid-packet while requester 0 waits.
    src_q[1].push_back(9'h010); src_q[1].push_back(9'h020);
    src_q[0].push_back(9'h10F);
    push_exp(8'hA1); push_exp(8'h10); push_exp(8'h20);
    wait_drain("stall_first_bytes", 40);
    @(posedge clk); #2;
    repeat (5) begin
      @(negedge clk);
      check("stall_tx_valid", 32'(tx_valid), 32'd0);
      check("stall_req_ready0", 32'(req_ready[0]), 32'd0);
      check("stall_grant_id", 32'(grant_id), 32'd1);
      check("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #2;
    src_q[1].push_back(9'h130);
    push_exp(8'h30); push_exp(8'hA0); push_exp(8'h0F);
    wait_drain("stall_resume", 40);

    // Truncation at MAX_PKT=4: a 6-byte packet is split into 4 + 2 bytes.
    do_reset();
    tc0 = trunc_cnt;
    src_q[0].push_back(9'h0D1); src_q[0].push_back(9'h0D2); src_q[0].push_back(9'h0D3);
    src_q[0].push_back(9'h0D4); src_q[0].push_back(9'h0D5); src_q[0].push_back(9'h1D6);
    push_exp(8'hA0); push_exp(8'hD1); push_exp(8'hD2); push_exp(8'hD3); push_exp(8'hD4);
    push_exp(8'hA0); push_exp(8'hD5); push_exp(8'hD6);
    wait_drain("trunc_split", 60);
    repeat (3) @(posedge clk);
    #2;
    check("trunc_pulse_count", 32'(trunc_cnt - tc0), 32'd1);

    // A last byte that lands exactly on MAX_PKT gives no truncation pulse.
    tc0 = trunc_cnt;
    src_q[0].push_back(9'h0E1); src_q[0].push_back(9'h0E2);
    src_q[0].push_back(9'h0E3); src_q[0].push_back(9'h1E4);
    push_exp(8'hA0); push_exp(8'hE1); push_exp(8'hE2); push_exp(8'hE3); push_exp(8'hE4);
    wait_drain("exact_max", 40);
    repeat (3) @(posedge clk);
    #2;
    check("exact_max_no_pulse", 32'(trunc_cnt - tc0), 32'd0);

    // Reset mid-DATA: requester 3 is granted, and a byte is on tx but held off by tx_ready.
    src_q[3].push_back(9'h0B1); src_q[3].push_back(9'h0B2);
    push_exp(8'hA3); push_exp(8'hB1); push_exp(8'hB2);
    wait_drain("rst_first_bytes", 40);
    tx_mode = 2;
    src_q[3].push_back(9'h0B3);
    repeat (2) @(posedge clk);
    #2;
    check("rst_pre_tx_valid", 32'(tx_valid), 32'd1);
    check("rst_pre_grant_id", 32'(grant_id), 32'd3);
    reset = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    for (int i = 0; i < NR; i++) src_q[i].delete();
    src_q[3].push_back(9'h1C1);
    tx_mode = 0;
    push_exp(8'hA3); push_exp(8'hC1);
    repeat (2) @(posedge clk);
    #2;
    check("rst_hold_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_hold_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_drain("rst_after", 40);
    check("rst_after_grant_id", 32'(grant_id), 32'd3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
